// File: rtl/parity_rx_pkg.sv
// Shared definitions for the parity serial receiver: state encoding,
// parity sense constants, frame geometry and the expected-parity helper.
package parity_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam int   FRAME_BITS = 32'sd11;

  // Even sense matches the transmit-side generator; odd sense inverts it.
  function automatic logic calc_parity(input logic [7:0] i_byte, input logic i_odd);
    return (^i_byte) ^ i_odd;
  endfunction

endpackage

// File: rtl/parity_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; idles high so a
// reset never looks like a start bit.
module rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: r_meta may resolve late, r_sync is the clean copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/parity_rx.sv
// Mid-bit sampling receiver for start + 8 data (LSB first) + parity + stop
// frames; reports the byte with parity and framing error flags.
module parity_rx
  import parity_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32'sd16,
  parameter int ODD_PARITY   = 32'sd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 32'sd2 - 32'sd1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 32'sd1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(32'sd1);
  localparam logic           ODD_BIT = (ODD_PARITY != 32'sd0) ? PAR_ODD : PAR_EVEN;

  logic          w_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par_bit;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          r_busy;

  rx_sync u_rx_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // Frame FSM with bit timing, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_shift      <= 8'h00;
      r_par_bit    <= 1'b0;
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            // A start bit that is high again at mid-bit was only a glitch.
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == 3'd7) begin
              r_state <= ST_PARITY;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt        <= '0;
            r_valid      <= 1'b1;
            r_data       <= r_shift;
            r_parity_err <= (r_par_bit != calc_parity(r_shift, ODD_BIT));
            r_frame_err  <= ~w_rx_s;
            // Leaving at mid-stop lets an immediately following start bit be caught.
            if (w_rx_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_parity_rx.sv
// Directed self-checking bench for parity_rx: even-parity instance for the
// main scenarios, odd-parity instance for the inverted-sense check.
module tb_parity_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_perr;
  logic       o_ferr;
  logic       o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0;
  int   v_cnt = 0;
  int   ov_cnt = 0;
  int   v_cyc = 0;
  int   busy_rise = 0;
  int   busy_fall = 0;
  int   dbl = 0;
  logic busy_q = 1'b0;
  logic valid_q = 1'b0;

  parity_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  parity_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .rx(rx), .data(o_data), .valid(o_valid),
    .parity_err(o_perr), .frame_err(o_ferr), .busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs on the falling edge: pulse counts and cycle stamps.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    busy_q  <= busy;
    valid_q <= valid;
    if (busy && !busy_q) busy_rise <= cyc;
    if (!busy && busy_q) busy_fall <= cyc;
    if (valid) begin
      v_cnt <= v_cnt + 1;
      v_cyc <= cyc;
    end
    if (valid && valid_q) dbl <= dbl + 1;
    if (o_valid) ov_cnt <= ov_cnt + 1;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic test_reset;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (data !== 8'h00 || valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: data=%h valid=%b perr=%b ferr=%b busy=%b, need 00 0 0 0 0",
               data, valid, parity_err, frame_err, busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    int v0;
    v0 = v_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy_before: busy=%b need 1", busy);
    end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: busy=%b valid=%b need 0 0", busy, valid);
    end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_tests++;
    if (v_cnt !== v0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_no_valid: valids=%0d busy=%b need %0d 0", v_cnt, busy, v0);
    end
  endtask

  task automatic test_good_frame;
    int v0;
    v0 = v_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (v_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL good_valid_count: got %0d need 1", v_cnt - v0);
    end
    n_tests++;
    if (data !== 8'hA5 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL good_frame: data=%h perr=%b ferr=%b need a5 0 0", data, parity_err, frame_err);
    end
    // busy is first seen in cycle t0+1, valid in cycle t0+169.
    n_tests++;
    if (v_cyc - busy_rise !== 168) begin
      n_fail++;
      $display("FAIL good_latency: valid-busy gap=%0d need 168", v_cyc - busy_rise);
    end
  endtask

  task automatic test_exhaustive_parity;
    int v0;
    v0 = v_cnt;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      send_frame(b, ^b, 1'b1);
      n_tests++;
      if (data !== b) begin
        n_fail++;
        $display("FAIL exh_data: got %h need %h", data, b);
      end
      n_tests++;
      if (parity_err !== 1'b0) begin
        n_fail++;
        $display("FAIL exh_perr: byte %h perr=%b need 0", b, parity_err);
      end
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (v_cnt - v0 !== 256) begin
      n_fail++;
      $display("FAIL exh_valid_count: got %0d need 256", v_cnt - v0);
    end
  endtask

  task automatic test_parity_error;
    send_frame(8'h01, 1'b0, 1'b1);
    n_tests++;
    if (data !== 8'h01 || parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_set: data=%h perr=%b need 01 1", data, parity_err);
    end
    send_frame(8'h03, 1'b0, 1'b1);
    n_tests++;
    if (data !== 8'h03 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clear: data=%h perr=%b need 03 0", data, parity_err);
    end
  endtask

  task automatic test_false_start;
    int v0;
    v0 = v_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (v_cnt !== v0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL false_start_ignored: valids=%0d busy=%b need %0d 0", v_cnt, busy, v0);
    end
    n_tests++;
    if (busy_fall - busy_rise !== 8) begin
      n_fail++;
      $display("FAIL false_start_busy_len: got %0d need 8", busy_fall - busy_rise);
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    n_tests++;
    if (data !== 8'h5A || parity_err !== 1'b0 || v_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL after_false_start: data=%h perr=%b valids=%0d need 5a 0 1", data, parity_err, v_cnt - v0);
    end
  endtask

  task automatic test_frame_error_break;
    int v0;
    v0 = v_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    n_tests++;
    if (v_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL break_valid_count: got %0d need 1", v_cnt - v0);
    end
    n_tests++;
    if (data !== 8'h3C || frame_err !== 1'b1 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_set: data=%h ferr=%b perr=%b need 3c 1 0", data, frame_err, parity_err);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL break_wait_high: busy=%b need 1", busy);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || v_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL break_release: busy=%b valids=%0d need 0 1", busy, v_cnt - v0);
    end
    send_frame(8'hFF, 1'b0, 1'b1);
    n_tests++;
    if (data !== 8'hFF || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_clear: data=%h ferr=%b perr=%b need ff 0 0", data, frame_err, parity_err);
    end
  endtask

  task automatic test_odd_parity;
    int v0;
    v0 = ov_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    n_tests++;
    if (o_data !== 8'h00 || o_perr !== 1'b0 || ov_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL odd_good: data=%h perr=%b valids=%0d need 00 0 1", o_data, o_perr, ov_cnt - v0);
    end
    send_frame(8'h00, 1'b0, 1'b1);
    n_tests++;
    if (o_data !== 8'h00 || o_perr !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_bad: data=%h perr=%b need 00 1", o_data, o_perr);
    end
  endtask

  task automatic test_valid_width;
    n_tests++;
    if (dbl !== 0) begin
      n_fail++;
      $display("FAIL valid_width: multi-cycle valid pulses=%0d need 0", dbl);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_good_frame();
    test_reset_midframe();
    test_exhaustive_parity();
    test_parity_error();
    test_false_start();
    test_frame_error_break();
    test_odd_parity();
    test_valid_width();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_rx.md
Name: parity_rx

Overview:
- Serial receiver that checks parity on each frame. It is the receiving end of the team's 8-bit parity generator path.
- Frame on the single-wire line `rx`: start bit (0), 8 data bits LSB first, 1 parity bit, stop bit (1).
- Samples each bit at mid-bit using a clock-count divider, then presents the received byte with parity-error and frame-error flags.
- Sits behind the board serial input pin and feeds lab display/LED logic.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit. Must be even and at least 4.
- ODD_PARITY, 0: 0 = even parity (parity bit = XOR of the 8 data bits, matching the generator); 1 = odd parity (inverted).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- data  out  8  last received byte; held until the next frame completes.
- valid  out  1  one-cycle pulse: data and the error flags were just updated.
- parity_err  out  1  parity mismatch on the last frame; held until the next valid.
- frame_err  out  1  stop bit sampled 0 on the last frame; held until the next valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: one clock, synchronous and active-high (decided).
  - Values while rst=1 at a clock edge: data=8'h00, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE.
  - Both sync flops reset to 1; all counters reset to 0.
  - rst mid-frame aborts the frame; no valid is produced.
- Input sync: 2-flop synchronizer; rx_s is the second flop. The FSM sees only rx_s, 2 cycles after rx.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. All outputs are registered.
- IDLE -> START when rx_s==0. Call this detection cycle t0; cycle counter cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1 (start sample, t0+CLKS_PER_BIT/2):
  - rx_s==1: false start, go to IDLE, no valid.
  - rx_s==0: go to DATA with cnt=0 and bit index=0.
- DATA: sample rx_s every CLKS_PER_BIT cycles (cnt==CLKS_PER_BIT-1) into shift register bit[idx], LSB first. After idx==7, go to PARITY.
- PARITY: sample one bit after CLKS_PER_BIT cycles; compute expected = (^shift) ^ ODD_PARITY.
- STOP: sample after CLKS_PER_BIT cycles. On the cycle after the stop sample:
  - valid=1, data<=shift, parity_err<=(sampled parity != expected), frame_err<=(stop==0).
- STOP exit: if stop==1 go to IDLE; if stop==0 go to WAIT_HIGH. WAIT_HIGH -> IDLE when rx_s==1, so a held-low line (break) does not retrigger.
- Timing with CLKS_PER_BIT=16: start sample t0+8, data bit i at t0+24+16i, parity at t0+152, stop at t0+168, valid high during cycle t0+169.
- Back-to-back frames: returning to IDLE at mid-stop allows a start edge arriving right after the stop bit to be caught.
- valid never exceeds 1 cycle. Error flags are updated only together with valid.
- cnt width: $clog2(CLKS_PER_BIT). idx: 3 bits, no wrap beyond 7.

Decomposition:
- Shared package (or include): state encoding localparams (3-bit), PAR_EVEN=0 / PAR_ODD=1 constants, frame length constant = 11 bits.
- One sub-module: rx_sync (2-flop synchronizer, reset value 1), reusable for other async inputs.
- FSM, counters and shift register stay in parity_rx.

Test Plan:
- Reset: hold rx=1 and pulse rst 3 cycles -> data=00, valid=0, both errors 0, busy=0. Assert rst mid-frame (during DATA) -> busy=0 next cycle, no valid pulse.
- Good frame, even parity: send 8'hA5 with parity 0, stop 1 -> one valid pulse, data=A5, parity_err=0, frame_err=0. Valid occurs 169 cycles after the sync-detected start edge.
- Exhaustive parity: loop i=0..255 with the correct parity bit = ^i -> 256 valid pulses, data==i each time, parity_err never set.
- Parity error: send 8'h01 with parity 0 -> data=01, parity_err=1. The next good frame 8'h03 with parity 0 -> parity_err clears to 0.
- False start: rx low for 4 cycles, then high -> no valid, busy returns to 0 at t0+9. A full frame sent afterwards is received correctly.
- Frame error and break: send 8'h3C with stop=0 and hold rx low 100 cycles -> valid once, data=3C, frame_err=1, stays in WAIT_HIGH with no retrigger. After rx returns high, the next frame 8'hFF with parity 0 -> frame_err=0.
- ODD_PARITY=1 instance: 8'h00 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1.
